// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized rxd, mid-bit sampling FSM, one-entry
// holding register with valid/ready handoff, framing-error and overrun pulses.
module uart_rx #(
    parameter int clk_hz    = 50_000_000,
    parameter int baud_rate = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int CLKS_PER_BIT = clk_hz / baud_rate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic          rxd_meta;
    logic          rxd_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= 3'd0;
            shreg        <= 8'h00;
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leaving at mid-stop lets an immediately following start bit be caught.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BRK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built bit-by-bit on rxd, expected
// bytes/errors queued at issue time, and a negedge monitor checks deliveries.
module tb_uart_rx;

    localparam int CLK_HZ = 1_700_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    uart_rx #(.clk_hz(CLK_HZ), .baud_rate(BAUD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int obs_ferr = 0;
    int obs_ovr  = 0;
    int ready_mode = 1;
    int valid_hi_cycles = 0;
    int valid_rise_cyc = -1;
    int last_start_cyc = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives a level starting now (posedge+1) for n whole clock periods.
    task automatic holdLine(input logic level, input int n);
        rxd = level;
        repeat (n) sync();
    endtask

    // kind: 0 byte expected, 1 framing error expected, 2 overrun expected, 3 nothing
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int kind, input int gap);
        case (kind)
            0: exp_q.push_back(data);
            1: exp_ferr++;
            2: exp_ovr++;
            default: ;
        endcase
        last_start_cyc = cyc;
        holdLine(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdLine(data[i], CPB);
        holdLine(stop_bit, CPB);
        if (gap > 0) holdLine(1'b1, gap);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        rx_ready = 1'b0;
        forever begin
            sync();
            case (ready_mode)
                0: rx_ready = 1'b0;
                1: rx_ready = 1'b1;
                default: rx_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and polices pulse/hold rules.
    initial begin
        logic       prev_valid = 1'b0;
        logic       prev_ready = 1'b0;
        logic       prev_ferr  = 1'b0;
        logic       prev_ovr   = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                prev_ferr  = 1'b0;
                prev_ovr   = 1'b0;
            end else begin
                if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
                if (rx_valid) valid_hi_cycles++;
                if (prev_valid && !prev_ready) begin
                    checkOutput("valid_hold", rx_valid, 1);
                    checkOutput("data_hold", rx_data, prev_data);
                end
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) checkOutput("unexpected_byte", 1, 0);
                    else checkOutput("rx_data", rx_data, exp_q.pop_front());
                end
                if (rx_frame_err) begin
                    obs_ferr++;
                    checkOutput("ferr_width", prev_ferr, 0);
                    checkOutput("ferr_excl", rx_overrun, 0);
                end
                if (rx_overrun) begin
                    obs_ovr++;
                    checkOutput("ovr_width", prev_ovr, 0);
                end
                prev_valid = rx_valid;
                prev_ready = rx_ready;
                prev_ferr  = rx_frame_err;
                prev_ovr   = rx_overrun;
                prev_data  = rx_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", rx_valid, 0);
        checkOutput("rst_data", rx_data, 0);
        checkOutput("rst_busy", rx_busy, 0);
        checkOutput("rst_ferr", rx_frame_err, 0);
        checkOutput("rst_ovr", rx_overrun, 0);
        rst = 1'b0;
        holdLine(1'b1, 5);

        $display("[TB] frame 0x55, ready high");
        valid_hi_cycles = 0;
        applyStimulus(8'h55, 1'b1, 0, 0);
        @(negedge clk);
        checkOutput("busy_after_stop", rx_busy, 0);
        waitDrain(50);
        // Sync (2) + IDLE detect (1) + half bit + 9 full bits, counted in posedges.
        checkOutput("latency", valid_rise_cyc - last_start_cyc, 3 + HALF + 9 * CPB);
        checkOutput("valid_one_clk", valid_hi_cycles, 1);
        checkOutput("t1_ferr", obs_ferr, exp_ferr);
        checkOutput("t1_ovr", obs_ovr, exp_ovr);
        sync();

        $display("[TB] start glitch");
        holdLine(1'b0, 5);
        holdLine(1'b1, 40);
        checkOutput("glitch_busy", rx_busy, 0);
        checkOutput("glitch_valid", rx_valid, 0);
        checkOutput("glitch_ferr", obs_ferr, exp_ferr);

        $display("[TB] bad stop then stuck low line");
        applyStimulus(8'hA3, 1'b0, 1, 0);
        holdLine(1'b0, 200);
        checkOutput("break_busy", rx_busy, 1);
        checkOutput("break_ferr", obs_ferr, exp_ferr);
        holdLine(1'b1, 10);
        applyStimulus(8'h5A, 1'b1, 0, CPB);
        waitDrain(50);
        checkOutput("t3_ferr", obs_ferr, exp_ferr);
        sync();

        $display("[TB] back-to-back 0x00, 0xFF");
        applyStimulus(8'h00, 1'b1, 0, 0);
        applyStimulus(8'hFF, 1'b1, 0, CPB);
        waitDrain(50);
        sync();

        $display("[TB] overrun with ready low");
        ready_mode = 0;
        applyStimulus(8'h11, 1'b1, 0, 0);
        applyStimulus(8'h22, 1'b1, 2, CPB);
        @(negedge clk);
        checkOutput("ovr_valid", rx_valid, 1);
        checkOutput("ovr_data", rx_data, 8'h11);
        checkOutput("ovr_count", obs_ovr, exp_ovr);
        ready_mode = 1;
        @(negedge clk);
        checkOutput("ovr_ready_seen", rx_ready, 1);
        checkOutput("ovr_valid_still", rx_valid, 1);
        @(negedge clk);
        checkOutput("ovr_valid_drop", rx_valid, 0);
        checkOutput("ovr_queue", exp_q.size(), 0);
        sync();

        $display("[TB] reset during data bit 4");
        ready_mode = 0;
        applyStimulus(8'h7E, 1'b1, 0, CPB);
        fork
            applyStimulus(8'hF0, 1'b1, 3, CPB);
            begin
                repeat (5 * CPB + HALF) @(posedge clk);
                #2;
                checkOutput("pre_rst_busy", rx_busy, 1);
                checkOutput("pre_rst_valid", rx_valid, 1);
                rst = 1'b1;
                #1;
                checkOutput("arst_valid", rx_valid, 0);
                checkOutput("arst_data", rx_data, 0);
                checkOutput("arst_busy", rx_busy, 0);
                exp_q.delete();
                repeat (3) @(posedge clk);
                #2;
                rst = 1'b0;
            end
        join
        ready_mode = 1;
        applyStimulus(8'h3C, 1'b1, 0, CPB);
        waitDrain(50);
        checkOutput("t6_ferr", obs_ferr, exp_ferr);
        checkOutput("t6_ovr", obs_ovr, exp_ovr);
        sync();

        $display("[TB] randomized frames");
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            logic       bad;
            int         gap;
            b   = 8'($urandom_range(255));
            bad = ($urandom_range(99) < 15);
            gap = bad ? $urandom_range(3 * CPB, 2) : $urandom_range(3 * CPB, 0);
            applyStimulus(b, !bad, bad ? 1 : 0, gap);
        end
        holdLine(1'b1, CPB);
        ready_mode = 1;
        waitDrain(100);
        checkOutput("final_ferr", obs_ferr, exp_ferr);
        checkOutput("final_ovr", obs_ovr, exp_ovr);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
